// File: rtl/bayer_to_gray_pkg.sv
// Shared pixel types, quad layout and luma weights for the Bayer-to-gray block.
package bayer_pkg;

  localparam int PIX_W = 12;
  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t g1;
    pix_t r;
    pix_t b;
    pix_t g2;
  } quad_t;

  localparam int unsigned W_R = 77;
  localparam int unsigned W_G = 75;
  localparam int unsigned W_B = 29;

  // Places the four raw samples of a quad into colour channels for either sensor phase.
  function automatic quad_t map_quad(input logic gr_first, input pix_t top_e, input pix_t top_o,
                                     input pix_t bot_e, input pix_t bot_o);
    quad_t q;
    if (gr_first) begin
      q.g1 = top_e;
      q.r  = top_o;
      q.b  = bot_e;
      q.g2 = bot_o;
    end else begin
      q.r  = top_e;
      q.g1 = top_o;
      q.g2 = bot_e;
      q.b  = bot_o;
    end
    return q;
  endfunction

endpackage

// File: rtl/bayer_to_gray_if.sv
// Pixel stream bundle: raw Bayer input side and gray output side of the converter.
interface bayer_to_gray_if #(
  parameter int X_W = 16
);
  import bayer_pkg::*;

  pix_t           iDATA;
  logic           iDVAL;
  logic [X_W-1:0] iX_Cont;
  logic [X_W-1:0] iY_Cont;
  pix_t           oGRAY;
  logic           oDVAL;
  logic [X_W-1:0] oX_Cont;
  logic [X_W-1:0] oY_Cont;

  modport slave (
    input  iDATA, iDVAL, iX_Cont, iY_Cont,
    output oGRAY, oDVAL, oX_Cont, oY_Cont
  );

  modport master (
    output iDATA, iDVAL, iX_Cont, iY_Cont,
    input  oGRAY, oDVAL, oX_Cont, oY_Cont
  );

endinterface

// File: rtl/bayer_to_gray_line_buf.sv
// Simple dual-port line RAM holding the even row of a quad pair; registered read with enable.
module bayer_line_buf #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int DW    = 24
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Array left without reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bayer_to_gray.sv
// Bayer 2x2 quad to one gray pixel, emitted on the odd row of each row pair.
// Macro BAYER_LUMA_WEIGHT_EN selects weighted luma with 2-clock latency; default is the 4-way average.
module bayer_to_gray
  import bayer_pkg::*;
#(
  parameter int LINE_W         = 1280,
  parameter int X_W            = 16,
  parameter int BAYER_GR_FIRST = 1
) (
  input logic            iCLK,
  input logic            iRST,
  bayer_to_gray_if.slave bus
);

  localparam int AW = (LINE_W > 2) ? $clog2(LINE_W / 2) : 1;
  localparam logic [X_W-1:0] LINE_W_X = X_W'(LINE_W);

  logic           beat, col_odd, row_odd, wr_en, rd_en, emit;
  logic [AW-1:0]  addr;
  logic [X_W-1:0] ox_in, oy_in;
  logic [23:0]    rd_data;
  quad_t          quad;

  pix_t           hold_q, hold_d;
  logic           row_valid_q, row_valid_d;
  pix_t           gray_q, gray_d;
  logic           dval_q, dval_d;
  logic [X_W-1:0] ox_q, ox_d, oy_q, oy_d;

  assign beat    = bus.iDVAL && (bus.iX_Cont < LINE_W_X);
  assign col_odd = bus.iX_Cont[0];
  assign row_odd = bus.iY_Cont[0];
  assign addr    = bus.iX_Cont[AW:1];
  assign wr_en   = beat && !row_odd && col_odd;
  assign rd_en   = beat && row_odd && !col_odd;
  assign emit    = beat && row_odd && col_odd && row_valid_q;
  assign ox_in   = {1'b0, bus.iX_Cont[X_W-1:1]};
  assign oy_in   = {1'b0, bus.iY_Cont[X_W-1:1]};

  bayer_line_buf #(
    .DEPTH(LINE_W / 2),
    .AW   (AW),
    .DW   (24)
  ) u_line_buf (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .we_i   (wr_en),
    .waddr_i(addr),
    .wdata_i({hold_q, bus.iDATA}),
    .re_i   (rd_en),
    .raddr_i(addr),
    .rdata_o(rd_data)
  );

  // Top row comes from the line buffer, bottom row from the hold register plus live pixel.
  assign quad = map_quad(BAYER_GR_FIRST != 0, rd_data[23:12], rd_data[11:0], hold_q, bus.iDATA);

  always_comb begin
    hold_d      = hold_q;
    row_valid_d = row_valid_q;
    if (beat && !col_odd) hold_d = bus.iDATA;
    if (wr_en && (addr == '0)) row_valid_d = 1'b1;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hold_q      <= '0;
      row_valid_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      row_valid_q <= row_valid_d;
    end
  end

`ifdef BAYER_LUMA_WEIGHT_EN
  logic [19:0]    acc_q, acc_d;
  logic           s1_dval_q;
  logic [X_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;

  // Weights sum to 256, so a full-scale quad lands exactly on 4095 after the shift.
  always_comb begin
    acc_d  = acc_q;
    s1_x_d = s1_x_q;
    s1_y_d = s1_y_q;
    if (emit) begin
      acc_d  = 20'(W_R) * 20'(quad.r) + 20'(W_G) * 20'(quad.g1)
             + 20'(W_G) * 20'(quad.g2) + 20'(W_B) * 20'(quad.b);
      s1_x_d = ox_in;
      s1_y_d = oy_in;
    end
    gray_d = gray_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    dval_d = s1_dval_q;
    if (s1_dval_q) begin
      gray_d = acc_q[19:8];
      ox_d   = s1_x_q;
      oy_d   = s1_y_q;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      acc_q     <= '0;
      s1_dval_q <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
    end else begin
      acc_q     <= acc_d;
      s1_dval_q <= emit;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
    end
  end
`else
  logic [13:0] sum4;

  always_comb begin
    sum4   = 14'(quad.g1) + 14'(quad.g2) + 14'(quad.r) + 14'(quad.b);
    gray_d = gray_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    dval_d = emit;
    if (emit) begin
      gray_d = sum4[13:2];
      ox_d   = ox_in;
      oy_d   = oy_in;
    end
  end
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      gray_q <= '0;
      dval_q <= 1'b0;
      ox_q   <= '0;
      oy_q   <= '0;
    end else begin
      gray_q <= gray_d;
      dval_q <= dval_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
    end
  end

  assign bus.oGRAY   = gray_q;
  assign bus.oDVAL   = dval_q;
  assign bus.oX_Cont = ox_q;
  assign bus.oY_Cont = oy_q;

endmodule

// File: tb/tb_bayer_to_gray.sv
// Randomised bench for bayer_to_gray against a pixel-array reference model; honours BAYER_LUMA_WEIGHT_EN.
module tb_bayer_to_gray;
  import bayer_pkg::*;

  localparam int LINE_W = 8;
  localparam int X_W    = 16;
`ifdef BAYER_LUMA_WEIGHT_EN
  localparam int LAT = 2;
  localparam int DIRECTED_GRAY = 129;
`else
  localparam int LAT = 1;
  localparam int DIRECTED_GRAY = 115;
`endif

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  bayer_to_gray_if #(.X_W(X_W)) bus ();

  bayer_to_gray #(
    .LINE_W        (LINE_W),
    .X_W           (X_W),
    .BAYER_GR_FIRST(1)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  always #5 iCLK = ~iCLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    int due;
    int gray;
    int x;
    int y;
  } exp_t;

  exp_t exp_q[$];
  int   got_q[$];
  int   ref_q[$];
  int   frame[4][LINE_W];
  int   top_pix[LINE_W];
  int   row_pix[LINE_W];
  bit   m_valid = 1'b0;
  int   exp_override = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // GR-first layout: top row = G1 R, bottom row = B G2.
  function automatic int ref_gray(int g1, int r, int b, int g2);
`ifdef BAYER_LUMA_WEIGHT_EN
    return (77 * r + 75 * g1 + 75 * g2 + 29 * b) / 256;
`else
    return (g1 + r + b + g2) / 4;
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iCLK); #1;
      bus.iDVAL   = 1'b0;
      bus.iDATA   = pix_t'($urandom);
      bus.iX_Cont = X_W'($urandom);
      bus.iY_Cont = X_W'($urandom);
    end
  endtask

  task automatic beat(input int x, input int y, input int d);
    exp_t e;
    @(posedge iCLK); #1;
    bus.iDVAL   = 1'b1;
    bus.iX_Cont = X_W'(x);
    bus.iY_Cont = X_W'(y);
    bus.iDATA   = pix_t'(d);
    if (x < LINE_W) begin
      if (y % 2 == 0) begin
        top_pix[x] = d;
        if (x == 1) m_valid = 1'b1;
      end else begin
        row_pix[x] = d;
        if ((x % 2 == 1) && m_valid) begin
          e.due  = cyc + LAT;
          e.gray = (exp_override >= 0) ? exp_override
                   : ref_gray(top_pix[x-1], top_pix[x], row_pix[x-1], d);
          e.x    = x / 2;
          e.y    = y / 2;
          exp_q.push_back(e);
          exp_override = -1;
        end
      end
    end
  endtask

  task automatic send_row(input int y, input int fr_row, input int maxgap, input bit oor);
    for (int x = 0; x < LINE_W; x++) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      beat(x, y, frame[fr_row][x]);
    end
    if (oor) for (int k = 0; k < 4; k++) beat(LINE_W + k, y, 4000);
  endtask

  task automatic send_frame(input int y0, input int maxgap, input bit oor);
    for (int r = 0; r < 4; r++) send_row(y0 + r, r, maxgap, oor);
  endtask

  task automatic fill(input bit rnd, input int val);
    for (int r = 0; r < 4; r++)
      for (int x = 0; x < LINE_W; x++)
        frame[r][x] = rnd ? int'($urandom_range(0, 4095)) : val;
  endtask

  task automatic drain();
    idle(LAT + 3);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge iCLK) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("dval", bus.oDVAL, 1);
      chk("gray", bus.oGRAY, exp_q[0].gray);
      chk("ox", bus.oX_Cont, exp_q[0].x);
      chk("oy", bus.oY_Cont, exp_q[0].y);
      got_q.push_back(int'(bus.oGRAY));
      void'(exp_q.pop_front());
    end else if (bus.oDVAL) begin
      chk("spurious_dval", bus.oDVAL, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iDVAL   = 1'b0;
    bus.iDATA   = '0;
    bus.iX_Cont = '0;
    bus.iY_Cont = '0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_gray", bus.oGRAY, 0);
    chk("rst_dval", bus.oDVAL, 0);
    chk("rst_ox", bus.oX_Cont, 0);
    chk("rst_oy", bus.oY_Cont, 0);
    iRST = 1'b0;

    // Odd row with no preceding even row: nothing may come out.
    fill(1'b1, 0);
    send_row(1, 1, 0, 1'b0);
    drain();

    fill(1'b0, 100);
    send_frame(0, 0, 1'b0);
    drain();
    chk("uniform_count", got_q.size(), 2 * (LINE_W / 2));

    fill(1'b1, 0);
    frame[0][0] = 100;
    frame[0][1] = 200;
    frame[1][0] = 40;
    frame[1][1] = 120;
    send_row(0, 0, 0, 1'b0);
    exp_override = DIRECTED_GRAY;
    send_row(1, 1, 0, 1'b0);
    drain();

    fill(1'b0, 4095);
    send_frame(4, 0, 1'b0);
    drain();

    fill(1'b1, 0);
    got_q.delete();
    send_frame(0, 0, 1'b0);
    drain();
    ref_q = got_q;
    got_q.delete();
    send_frame(0, 5, 1'b0);
    drain();
    chk("gap_seq_len", got_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) chk("gap_seq", got_q[i], ref_q[i]);

    // Reset during an odd row, just as a quad result leaves the pipe.
    fill(1'b1, 0);
    send_row(0, 0, 0, 1'b0);
    for (int x = 0; x < 4; x++) beat(x, 1, frame[1][x]);
    @(posedge iCLK); #1;
    bus.iDVAL = 1'b0;
    iRST      = 1'b1;
    exp_q.delete();
    m_valid = 1'b0;
    #1;
    chk("rst_kill_dval", bus.oDVAL, 0);
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    for (int x = 4; x < LINE_W; x++) beat(x, 1, frame[1][x]);
    send_row(2, 2, 0, 1'b0);
    send_row(3, 3, 0, 1'b0);
    drain();

    for (int n = 0; n < 4; n++) begin
      fill(1'b1, 0);
      send_frame(4 * n, 3, 1'b1);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
